// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use, branch-operand and mul/div HI/LO interlocks.
// Optional stall-cycle counter (STALL_CNT) is built only when HAZ_STALL_COUNT_EN is defined.
module hazard_controller #(
   parameter int unsigned MD_LATENCY = 8
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [4:0] IF_ID_RS,
   input  logic [4:0] IF_ID_RT,
   input  logic [4:0] ID_EX_RT,
   input  logic [4:0] ID_EX_RD,
   input  logic       ID_EX_MEMREAD,
   input  logic       ID_EX_REGWRITE,
   input  logic [4:0] EX_MEM_RD,
   input  logic       EX_MEM_MEMREAD,
   input  logic       ID_BRANCH,
   input  logic       ID_MD_START,
   input  logic       ID_READS_HILO,
   input  logic       BRANCH_TAKEN,
   output logic       PC_WRITE,
   output logic       IF_ID_WRITE,
   output logic       ID_EX_BUBBLE,
   output logic       IF_ID_FLUSH,
   output logic       MD_BUSY,
   output logic       MD_DONE
`ifdef HAZ_STALL_COUNT_EN
   ,
   output logic [15:0] STALL_CNT
`endif
);

   localparam int unsigned CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

   typedef enum logic {RUN, MD_WAIT} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             done_nxt;
   logic             lu_stall, br_stall, md_stall, stall;

   // True when reg is nonzero and names one of the ID-stage sources.
   function automatic logic src_hit(input logic [4:0] r, input logic [4:0] rs,
                                    input logic [4:0] rt);
      return (r != 5'd0) && ((r == rs) || (r == rt));
   endfunction

   // Hazard detection and pipeline control.
   always_comb begin
      lu_stall = ID_EX_MEMREAD && src_hit(ID_EX_RT, IF_ID_RS, IF_ID_RT);
      br_stall = ID_BRANCH &&
                 ((ID_EX_REGWRITE && src_hit(ID_EX_RD, IF_ID_RS, IF_ID_RT)) ||
                  (EX_MEM_MEMREAD && src_hit(EX_MEM_RD, IF_ID_RS, IF_ID_RT)));
      md_stall = (state == MD_WAIT) && (ID_MD_START || ID_READS_HILO);
      stall    = lu_stall || br_stall || md_stall;

      PC_WRITE     = !stall;
      IF_ID_WRITE  = !stall;
      ID_EX_BUBBLE = stall;
      IF_ID_FLUSH  = !stall && BRANCH_TAKEN;
      MD_BUSY      = (state == MD_WAIT);
   end

   // Mul/div sequencing: count down MD_LATENCY-1..0, then flag completion.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      case (state)
         RUN: begin
            if (ID_MD_START && !stall) begin
               cnt_nxt   = CNT_W'(MD_LATENCY - 1);
               state_nxt = MD_WAIT;
            end
         end
         MD_WAIT: begin
            if (cnt == '0) begin
               state_nxt = RUN;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= RUN;
         cnt     <= '0;
         MD_DONE <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         MD_DONE <= done_nxt;
      end
   end

`ifdef HAZ_STALL_COUNT_EN
   // Saturating count of stalled cycles.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         STALL_CNT <= 16'd0;
      end else if (stall && (STALL_CNT != 16'hFFFF)) begin
         STALL_CNT <= STALL_CNT + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: driver pushes model expectations, negedge monitor compares.
module tb_hazard_controller;
   localparam int unsigned L = 8;

   typedef struct {
      logic       rst;
      logic [4:0] rs, rt, ex_rt, ex_rd, mem_rd;
      logic       ex_mr, ex_rw, mem_mr, br, start, hilo, taken;
   } stim_t;

   typedef struct {
      int          cyc;
      logic        pcw, ifw, bub, flush, busy, done;
      logic [15:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rs, rt, ex_rt, ex_rd, mem_rd;
   logic       ex_mr, ex_rw, mem_mr, br, md_start, hilo, taken;
   logic       pc_write, if_id_write, bubble, flush, md_busy, md_done;
`ifdef HAZ_STALL_COUNT_EN
   logic [15:0] stall_cnt;
`endif

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model state: cycle index, last mul/div issue cycle, stall tally.
   int   cyc = 0;
   bit   md_active = 1'b0;
   int   md_issue = 0;
   int   stall_count = 0;

   always #5 clk = ~clk;

   hazard_controller #(.MD_LATENCY(L)) dut (
      .CLK(clk), .RST_N(rst_n),
      .IF_ID_RS(rs), .IF_ID_RT(rt),
      .ID_EX_RT(ex_rt), .ID_EX_RD(ex_rd),
      .ID_EX_MEMREAD(ex_mr), .ID_EX_REGWRITE(ex_rw),
      .EX_MEM_RD(mem_rd), .EX_MEM_MEMREAD(mem_mr),
      .ID_BRANCH(br), .ID_MD_START(md_start), .ID_READS_HILO(hilo),
      .BRANCH_TAKEN(taken),
      .PC_WRITE(pc_write), .IF_ID_WRITE(if_id_write), .ID_EX_BUBBLE(bubble),
      .IF_ID_FLUSH(flush), .MD_BUSY(md_busy), .MD_DONE(md_done)
`ifdef HAZ_STALL_COUNT_EN
      , .STALL_CNT(stall_cnt)
`endif
   );

   function automatic stim_t idle();
      stim_t s;
      s.rst = 1'b1; s.rs = '0; s.rt = '0; s.ex_rt = '0; s.ex_rd = '0; s.mem_rd = '0;
      s.ex_mr = 0; s.ex_rw = 0; s.mem_mr = 0; s.br = 0; s.start = 0; s.hilo = 0; s.taken = 0;
      return s;
   endfunction

   function automatic bit src_match(input stim_t s, input logic [4:0] r);
      return (r != 5'd0) && (r == s.rs || r == s.rt);
   endfunction

   // Apply one cycle of stimulus and queue what the spec says the DUT shows in it.
   task automatic drive(input stim_t s);
      exp_t e;
      bit   lu, brh, md, stall, busy;
      @(posedge clk);
      #1;
      rst_n = s.rst; rs = s.rs; rt = s.rt; ex_rt = s.ex_rt; ex_rd = s.ex_rd;
      mem_rd = s.mem_rd; ex_mr = s.ex_mr; ex_rw = s.ex_rw; mem_mr = s.mem_mr;
      br = s.br; md_start = s.start; hilo = s.hilo; taken = s.taken;

      if (!s.rst) begin
         md_active   = 1'b0;
         stall_count = 0;
      end
      busy   = s.rst && md_active && cyc > md_issue && cyc <= md_issue + int'(L);
      e.done = s.rst && md_active && cyc == md_issue + int'(L) + 1;
      lu     = s.ex_mr && src_match(s, s.ex_rt);
      brh    = s.br && ((s.ex_rw && src_match(s, s.ex_rd)) ||
                        (s.mem_mr && src_match(s, s.mem_rd)));
      md     = busy && (s.start || s.hilo);
      stall  = lu || brh || md;

      e.cyc   = cyc;
      e.pcw   = !stall;
      e.ifw   = !stall;
      e.bub   = stall;
      e.flush = !stall && s.taken;
      e.busy  = busy;
      e.cnt   = 16'(stall_count);
      exp_q.push_back(e);

      if (s.rst) begin
         if (stall && stall_count < 65535) stall_count++;
         if (s.start && !stall) begin
            md_active = 1'b1;
            md_issue  = cyc;
         end
      end
      cyc++;
   endtask

   task automatic check(input string name, input int c, input logic [15:0] act,
                        input logic [15:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, act, exp);
      end
   endtask

   // Monitor: one expectation per cycle, sampled mid-cycle.
   always @(negedge clk) begin : mon
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         check("pc_write",    e.cyc, 16'(pc_write),    16'(e.pcw));
         check("if_id_write", e.cyc, 16'(if_id_write), 16'(e.ifw));
         check("id_ex_bubble",e.cyc, 16'(bubble),      16'(e.bub));
         check("if_id_flush", e.cyc, 16'(flush),       16'(e.flush));
         check("md_busy",     e.cyc, 16'(md_busy),     16'(e.busy));
         check("md_done",     e.cyc, 16'(md_done),     16'(e.done));
`ifdef HAZ_STALL_COUNT_EN
         check("stall_cnt",   e.cyc, stall_cnt,        e.cnt);
`endif
      end
   end

   initial begin
      stim_t s;
      rst_n = 1'b0; rs = '0; rt = '0; ex_rt = '0; ex_rd = '0; mem_rd = '0;
      ex_mr = 0; ex_rw = 0; mem_mr = 0; br = 0; md_start = 0; hilo = 0; taken = 0;

      s = idle(); s.rst = 1'b0;
      repeat (3) drive(s);

      // Load-use hit, then zero-register cases.
      s = idle(); s.ex_mr = 1; s.ex_rt = 5; s.rs = 5; drive(s);
      drive(idle());
      s.ex_rt = 0; drive(s);
      s.ex_rt = 5; s.rs = 0; drive(s);

      // Branch after ALU op; branch after load (EX then MEM); then taken.
      s = idle(); s.br = 1; s.ex_rw = 1; s.ex_rd = 8; s.rt = 8; drive(s);
      s = idle(); s.br = 1; s.rt = 8; s.ex_mr = 1; s.ex_rt = 8; s.ex_rw = 1; s.ex_rd = 8; drive(s);
      s = idle(); s.br = 1; s.rt = 8; s.mem_mr = 1; s.mem_rd = 8; drive(s);
      s = idle(); s.br = 1; s.rt = 8; s.taken = 1; drive(s);

      // Taken branch masked by a load-use stall.
      s = idle(); s.taken = 1; s.ex_mr = 1; s.ex_rt = 3; s.rs = 3; drive(s);

      // Mul/div with mfhi waiting from cycle 3 until issue.
      s = idle(); s.start = 1; drive(s);
      drive(idle()); drive(idle());
      s = idle(); s.hilo = 1; repeat (7) drive(s);
      repeat (3) drive(idle());

      // Back-to-back mul/div: second start held until the first retires.
      s = idle(); s.start = 1; repeat (10) drive(s);
      repeat (10) drive(idle());

      // Reset in the middle of MD_WAIT.
      s = idle(); s.start = 1; drive(s);
      repeat (3) drive(idle());
      s = idle(); s.rst = 0; drive(s); drive(s);
      repeat (12) drive(idle());

      // Randomized traffic with small register indices to provoke matches.
      for (int i = 0; i < 3000; i++) begin
         s.rst    = ($urandom_range(0, 199) != 0);
         s.rs     = 5'($urandom_range(0, 7));
         s.rt     = 5'($urandom_range(0, 7));
         s.ex_rt  = 5'($urandom_range(0, 7));
         s.ex_rd  = 5'($urandom_range(0, 7));
         s.mem_rd = 5'($urandom_range(0, 7));
         s.ex_mr  = ($urandom_range(0, 3) == 0);
         s.ex_rw  = ($urandom_range(0, 1) == 0);
         s.mem_mr = ($urandom_range(0, 3) == 0);
         s.br     = ($urandom_range(0, 2) == 0);
         s.start  = ($urandom_range(0, 7) == 0);
         s.hilo   = ($urandom_range(0, 3) == 0);
         s.taken  = ($urandom_range(0, 1) == 0);
         drive(s);
      end

`ifdef HAZ_STALL_COUNT_EN
      // Drive the stall counter into saturation.
      s = idle(); s.rst = 0; drive(s);
      s = idle(); s.ex_mr = 1; s.ex_rt = 1; s.rs = 1;
      repeat (65540) drive(s);
`endif
      drive(idle());

      repeat (2) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
      end
      if (vectors == 0) begin
         miscompares++;
         $display("FAIL no_vectors got=0 expected>0");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL have parameter MD_LATENCY, default 8, meaning cycles from mul/div issue until HI/LO are valid (legal range 2..255).
REQ-002 The block SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have ports IF_ID_RS and IF_ID_RT  input  5 each  source registers of the instruction in ID.
REQ-005 The block SHALL have ports ID_EX_RT and ID_EX_RD  input  5 each  load destination and final ALU destination of the instruction in EX.
REQ-006 The block SHALL have ports ID_EX_MEMREAD and ID_EX_REGWRITE  input  1 each  EX instruction is a load / writes a register.
REQ-007 The block SHALL have ports EX_MEM_RD  input  5 and EX_MEM_MEMREAD  input  1  load destination in MEM.
REQ-008 The block SHALL have ports ID_BRANCH, ID_MD_START, ID_READS_HILO and BRANCH_TAKEN  input  1 each  ID instruction is a branch, a mul/div, or an mfhi/mflo; branch resolved taken in ID.
REQ-009 The block SHALL have outputs PC_WRITE, IF_ID_WRITE, ID_EX_BUBBLE, IF_ID_FLUSH, MD_BUSY and MD_DONE  output  1 each.
REQ-010 The block SHALL have output STALL_CNT  output  16  stall cycle count, present only when HAZ_STALL_COUNT_EN is defined.

Function
REQ-011 A source register equal to 0 SHALL never cause a stall.
REQ-012 Load-use stall SHALL be raised when ID_EX_MEMREAD=1 and ID_EX_RT equals a nonzero IF_ID_RS or IF_ID_RT.
REQ-013 Branch stall SHALL be raised when ID_BRANCH=1 and either ID_EX_REGWRITE=1 with ID_EX_RD matching a nonzero source, or EX_MEM_MEMREAD=1 with EX_MEM_RD matching a nonzero source.
REQ-014 Mul/div stall SHALL be raised when the state is MD_WAIT and ID_MD_START or ID_READS_HILO is 1.
REQ-015 During any stall, PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1 and IF_ID_FLUSH=0, combinationally in the same cycle.
REQ-016 With no stall, PC_WRITE=1, IF_ID_WRITE=1, ID_EX_BUBBLE=0 and IF_ID_FLUSH=BRANCH_TAKEN.
REQ-017 BRANCH_TAKEN SHALL be ignored in any cycle in which a stall is raised.
REQ-018 The FSM SHALL have states RUN and MD_WAIT, and the state SHALL be registered.
REQ-019 In RUN, ID_MD_START=1 with no stall SHALL load the counter with MD_LATENCY-1 and enter MD_WAIT at the next edge.
REQ-020 In MD_WAIT, the counter SHALL decrement by 1 each cycle, and MD_BUSY SHALL be 1 combinationally from state.
REQ-021 In MD_WAIT with counter=0, the FSM SHALL return to RUN, and MD_DONE SHALL be registered high for exactly the following cycle.
REQ-022 A mul/div stalled in MD_WAIT SHALL issue in the first RUN cycle, with no extra bubble.
REQ-023 The counter SHALL be ceil(log2(MD_LATENCY)) bits wide and SHALL never wrap below 0.

Reset
REQ-024 While RST_N=0, state SHALL be RUN, counter 0, MD_DONE=0, MD_BUSY=0, and STALL_CNT=0 (if present).
REQ-025 Combinational outputs SHALL follow REQ-015/016 from inputs during reset.
REQ-026 Reset asserted mid-MD_WAIT SHALL abort the operation, and no MD_DONE pulse SHALL be produced.

Configuration
REQ-027 With HAZ_STALL_COUNT_EN defined, STALL_CNT SHALL increment by 1 on every clock edge at which a stall is raised, and SHALL saturate at 16'hFFFF.
REQ-028 Without HAZ_STALL_COUNT_EN, the STALL_CNT port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Load-use: ID_EX_MEMREAD=1, ID_EX_RT=5, IF_ID_RS=5 -> PC_WRITE=0, ID_EX_BUBBLE=1 for one cycle; with ID_EX_RT=0 or IF_ID_RS=0 -> no stall.
REQ-030 Branch after ALU op: ID_BRANCH=1, ID_EX_REGWRITE=1, ID_EX_RD=8, IF_ID_RT=8 -> 1 stall cycle; branch after load (load advances to MEM, EX_MEM_RD=8) -> 2 consecutive stall cycles.
REQ-031 Mul/div: MD_LATENCY=8, ID_MD_START pulsed at cycle 0 -> MD_BUSY=1 for cycles 1..8, MD_DONE=1 at cycle 9 only; mfhi in ID at cycle 3 -> stalled through cycle 8, issued at cycle 9.
REQ-032 Taken branch: BRANCH_TAKEN=1 with no hazard -> IF_ID_FLUSH=1; same cycle with load-use hazard -> IF_ID_FLUSH=0.
REQ-033 Reset mid-op: RST_N low at cycle 4 of MD_WAIT -> MD_BUSY=0 immediately; no MD_DONE; STALL_CNT=0.
REQ-034 Counter (HAZ_STALL_COUNT_EN): 3 load-use stalls plus an 8-cycle mfhi stall -> STALL_CNT=11; forced saturation -> STALL_CNT holds 16'hFFFF.
